tx_stream_controller: RTL and testbench

- Read-side counterpart of the receive/write addressing path: once processing is over, streams the down-sampled output image from block RAM to the UART transmitter, one byte per transmit handshake.
- Synchronous replacement for the edge-triggered transmit addressing.
- Sits between the shared image BRAM read port and the UART TX core.
- Generates read addresses, absorbs BRAM read latency, loads bytes into the transmitter, counts bytes and raises tx_finish.

---
 rtl/tx_stream_controller_pkg.sv | 9 +
 rtl/tx_stream_controller_if.sv | 24 ++
 rtl/tx_stream_controller.sv | 78 +++++++
 tb/tb_tx_stream_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_stream_controller_pkg.sv
// tx_stream_controller_pkg: shared FSM states and image memory map for the UART image path
package tx_stream_controller_pkg;
   typedef enum logic [2:0] {IDLE, RD, WAIT, LOAD, SEND, FINISH} state_t;
   localparam int ADDR_W   = 18;
   localparam int IN_BASE  = 7;
   localparam int OUT_BASE = 65543;
   localparam int IN_SIZE  = 65536;
   localparam int OUT_SIZE = 16257;
endpackage

// File: rtl/tx_stream_controller_if.sv
// tx_stream_controller_if: BRAM read port plus UART TX handshake seen by the stream controller
interface tx_stream_controller_if #(
   parameter int ADDR_W = tx_stream_controller_pkg::ADDR_W,
   parameter int DATA_W = 8
);
   logic              start;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_dout;
   logic [DATA_W-1:0] tx_data;
   logic              tx_load;
   logic              tx_busy;
   logic              tx_done;
   logic              tx_finish;
   logic [ADDR_W-1:0] byte_count;
   modport master (
      input  start, mem_dout, tx_busy, tx_done,
      output mem_rd_en, mem_addr, tx_data, tx_load, tx_finish, byte_count
   );
   modport slave (
      output start, mem_dout, tx_busy, tx_done,
      input  mem_rd_en, mem_addr, tx_data, tx_load, tx_finish, byte_count
   );
endinterface

// File: rtl/tx_stream_controller.sv
// tx_stream_controller: streams the output image from BRAM into the UART TX, one byte per handshake
module tx_stream_controller #(
   parameter int ADDR_W    = tx_stream_controller_pkg::ADDR_W,
   parameter int DATA_W    = 8,
   parameter int BASE_ADDR = tx_stream_controller_pkg::OUT_BASE,
   parameter int OUT_SIZE  = tx_stream_controller_pkg::OUT_SIZE,
   parameter int MEM_LAT   = 1
) (
   input logic                    clk,
   input logic                    rst,
   tx_stream_controller_if.master bus
);
   import tx_stream_controller_pkg::*;
   if (longint'(BASE_ADDR) + longint'(OUT_SIZE) > (longint'(1) << ADDR_W)) begin : g_bad_range
      $fatal(1, "tx_stream_controller: BASE_ADDR+OUT_SIZE-1 does not fit in ADDR_W bits");
   end
   if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
      $fatal(1, "tx_stream_controller: MEM_LAT must be 1..3");
   end
   state_t            state;
   logic [1:0]        lat;
   logic [ADDR_W-1:0] next_count;
   assign next_count = bus.byte_count + ADDR_W'(1);
   // FSM: the load strobe is decided one cycle early so a free transmitter is loaded MEM_LAT+1 cycles after RD
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         lat            <= '0;
         bus.mem_rd_en  <= 1'b0;
         bus.mem_addr   <= ADDR_W'(BASE_ADDR);
         bus.tx_data    <= DATA_W'(0);
         bus.tx_load    <= 1'b0;
         bus.tx_finish  <= 1'b0;
         bus.byte_count <= '0;
      end else begin
         bus.mem_rd_en <= 1'b0;
         bus.tx_load   <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               if (OUT_SIZE == 0) begin
                  state         <= FINISH;
                  bus.tx_finish <= 1'b1;
               end else begin
                  state         <= RD;
                  bus.mem_rd_en <= 1'b1;
                  bus.mem_addr  <= ADDR_W'(BASE_ADDR) + bus.byte_count;
               end
            end
            RD: begin
               state <= WAIT;
               lat   <= '0;
            end
            WAIT: if (lat == 2'(MEM_LAT - 1)) begin
               state       <= LOAD;
               bus.tx_data <= DATA_W'(bus.mem_dout);
               bus.tx_load <= !bus.tx_busy;
            end else begin
               lat <= lat + 2'd1;
            end
            LOAD: if (bus.tx_load) state <= SEND;
                  else bus.tx_load <= !bus.tx_busy;
            SEND: if (bus.tx_done) begin
               bus.byte_count <= next_count;
               if (next_count == ADDR_W'(OUT_SIZE)) begin
                  state         <= FINISH;
                  bus.tx_finish <= 1'b1;
               end else begin
                  state         <= RD;
                  bus.mem_rd_en <= 1'b1;
                  bus.mem_addr  <= ADDR_W'(BASE_ADDR) + next_count;
               end
            end
            FINISH: state <= FINISH;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tx_stream_controller.sv
// tb_tx_stream_controller: three controllers (basic, empty image, slow BRAM) against a cycle-level reference model
module tb_tx_stream_controller;
   localparam int NI   = 3;
   localparam int BASE = 10;
   localparam int SZ [NI] = '{4, 0, 4};
   localparam int LT [NI] = '{1, 1, 3};
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rs [NI] = '{1'b1, 1'b1, 1'b1};
   logic st [NI] = '{1'b0, 1'b0, 1'b0};
   logic hold = 1'b0, man = 1'b0, son = 1'b0;
   logic rd [NI], ld [NI], fo [NI], bz [NI], gd [NI];
   logic [17:0] addr [NI], bc [NI];
   logic [7:0] txd [NI];
   logic [7:0] lit [4] = '{8'hAF, 8'hAE, 8'hA9, 8'hA8};
   logic [7:0] q [NI][$];
   int nd [NI], nl [NI], fa [NI];
   int errors = 0, checks = 0;
   logic stray;
   assign stray = man | (son & ld[0]);
   for (genvar g = 0; g < NI; g++) begin : u
      tx_stream_controller_if #(.ADDR_W(18), .DATA_W(8)) ifc ();
      tx_stream_controller #(.ADDR_W(18), .DATA_W(8), .BASE_ADDR(BASE), .OUT_SIZE(SZ[g]), .MEM_LAT(LT[g]))
         dut (.clk(clk), .rst(rs[g]), .bus(ifc.master));
      logic [7:0] p1 = '0, p2 = '0, p3 = '0;
      logic ub = 1'b0, ud = 1'b0;
      int tm = 0;
      // BRAM pipeline of depth MEM_LAT and a UART that stays busy 20 cycles then pulses done
      always @(posedge clk) begin
         if (ifc.mem_rd_en) p1 <= ifc.mem_addr[7:0] ^ 8'hA5;
         p2 <= p1;
         p3 <= p2;
         if (rs[g]) begin
            ub <= 1'b0;
            ud <= 1'b0;
            tm <= 0;
         end else begin
            ud <= 1'b0;
            if (ifc.tx_load) begin
               ub <= 1'b1;
               tm <= 20;
            end else if (tm > 0) begin
               tm <= tm - 1;
               if (tm == 1) begin
                  ub <= 1'b0;
                  ud <= 1'b1;
               end
            end
         end
      end
      assign ifc.mem_dout = (LT[g] == 3) ? p3 : (LT[g] == 2) ? p2 : p1;
      assign ifc.start    = st[g];
      assign ifc.tx_busy  = ub | ((g == 0) && hold);
      assign ifc.tx_done  = ud | ((g == 0) && stray);
      assign rd[g]   = ifc.mem_rd_en;
      assign ld[g]   = ifc.tx_load;
      assign fo[g]   = ifc.tx_finish;
      assign bz[g]   = ifc.tx_busy;
      assign gd[g]   = ud;
      assign addr[g] = ifc.mem_addr;
      assign bc[g]   = ifc.byte_count;
      assign txd[g]  = ifc.tx_data;
   end
   function automatic logic [7:0] exp_byte(int k);
      return 8'(BASE + k) ^ 8'hA5;
   endfunction
   task automatic chk(string n, int i, longint act, longint ex);
      checks++;
      if (act != ex) begin
         errors++;
         $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", n, i, $time, act, ex);
      end
   endtask
   // Reference: byte k goes out MEM_LAT+2 cycles after its trigger (start or tx_done), then waits for a free UART
   task automatic monitor();
      int cyc = 0;
      int cnt [NI], lds [NI], due [NI];
      bit fin [NI], go [NI], aw [NI], pb [NI];
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < NI; i++) begin
            bit el;
            el = aw[i] && cyc >= due[i] && !pb[i];
            chk("byte_count", i, bc[i], cnt[i]);
            chk("tx_finish", i, fo[i], fin[i]);
            chk("tx_load", i, ld[i], el);
            chk("mem_rd_en", i, rd[i], aw[i] && cyc == due[i] - LT[i] - 1);
            if (rd[i]) chk("mem_addr", i, addr[i], BASE + cnt[i]);
            if (aw[i] && cyc >= due[i]) chk("tx_data", i, txd[i], exp_byte(lds[i]));
            if (ld[i]) begin
               nl[i]++;
               q[i].push_back(txd[i]);
            end
            if (rd[i] && fa[i] < 0) fa[i] = int'(addr[i]);
            if (el) begin
               aw[i] = 0;
               lds[i]++;
            end
            if (rs[i]) begin
               cnt[i] = 0; lds[i] = 0; fin[i] = 0; go[i] = 0; aw[i] = 0;
               nd[i] = 0; nl[i] = 0; fa[i] = -1;
               q[i].delete();
            end else begin
               if (!go[i] && st[i]) begin
                  go[i] = 1;
                  if (SZ[i] == 0) fin[i] = 1;
                  else begin aw[i] = 1; due[i] = cyc + LT[i] + 2; end
               end
               if (gd[i] && go[i] && !fin[i]) begin
                  cnt[i]++;
                  nd[i]++;
                  if (cnt[i] == SZ[i]) fin[i] = 1;
                  else begin aw[i] = 1; due[i] = cyc + LT[i] + 2; end
               end
            end
            pb[i] = bz[i];
         end
      end
   endtask
   task automatic wait_done(int i, int n, int budget);
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (nd[i] >= n) return;
      end
      chk("timeout tx_done", i, nd[i], n);
   endtask
   task automatic check_stream(int i);
      chk("final byte_count", i, bc[i], 4);
      chk("final tx_finish", i, fo[i], 1);
      chk("tx_load pulses", i, nl[i], 4);
      chk("first address", i, fa[i], BASE);
      chk("byte total", i, q[i].size(), 4);
      for (int k = 0; k < 4 && k < q[i].size(); k++) chk("stream byte", i, q[i][k], lit[k]);
   endtask
   initial begin
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("reset mem_addr", i, addr[i], BASE);
         chk("reset mem_rd_en", i, rd[i], 0);
         chk("reset tx_data", i, txd[i], 0);
         chk("reset tx_load", i, ld[i], 0);
      end
      rs = '{1'b0, 1'b0, 1'b0};
      man = 1'b1;
      @(posedge clk);
      #1;
      man = 1'b0;
      chk("idle stray byte_count", 0, bc[0], 0);
      chk("empty finish before start", 1, fo[1], 0);
      son = 1'b1;
      st = '{1'b1, 1'b1, 1'b1};
      @(posedge clk);
      #1;
      chk("empty finish after start", 1, fo[1], 1);
      wait_done(0, 1, 200);
      #1;
      hold = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("held tx_load", 0, ld[0], 0);
      hold = 1'b0;
      @(posedge clk);
      #1;
      chk("load after busy falls", 0, ld[0], 1);
      wait_done(0, 4, 300);
      wait_done(2, 4, 300);
      repeat (2) @(posedge clk);
      #1;
      check_stream(0);
      check_stream(2);
      chk("empty tx_load pulses", 1, nl[1], 0);
      chk("empty reads", 1, fa[1], -1);
      chk("empty byte_count", 1, bc[1], 0);
      rs[0] = 1'b1;
      st[0] = 1'b0;
      @(posedge clk);
      #1;
      rs[0] = 1'b0;
      st[0] = 1'b1;
      wait_done(0, 2, 200);
      #1;
      rs[0] = 1'b1;
      st[0] = 1'b0;
      @(posedge clk);
      #1;
      rs[0] = 1'b0;
      chk("abort byte_count", 0, bc[0], 0);
      chk("abort mem_addr", 0, addr[0], BASE);
      chk("abort tx_finish", 0, fo[0], 0);
      repeat (40) @(posedge clk);
      #1;
      chk("abort tx_load pulses", 0, nl[0], 0);
      st[0] = 1'b1;
      wait_done(0, 4, 300);
      repeat (2) @(posedge clk);
      #1;
      check_stream(0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
